// File: rtl/dmem_bus_bridge_if.sv
// Data-bus interface between dmem_bus_bridge (master) and the SoC data bus (slave).
// Carries the valid/ready request channel and the read-data/error response.
interface dmem_bus_bridge_if #(
    parameter int ADDR_W = 32
);
    logic              bus_valid;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_we;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic              bus_ready;
    logic [31:0]       bus_rdata;
    logic              bus_err;

    modport master (
        output bus_valid, bus_addr, bus_we, bus_be, bus_wdata,
        input  bus_ready, bus_rdata, bus_err
    );

    modport slave (
        input  bus_valid, bus_addr, bus_we, bus_be, bus_wdata,
        output bus_ready, bus_rdata, bus_err
    );
endinterface

// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: converts the core LSU data request into one valid/ready bus
// transaction, stalling the core until the transaction completes.
// Optional feature macro: BUS_TIMEOUT_EN -- aborts a REQ that waits
// TIMEOUT_CYCLES cycles without bus_ready and returns ERR_RDATA.
module dmem_bus_bridge #(
    parameter int          ADDR_W         = 32,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [3:0]        datamem_wr,
    input  logic [7:0]        data_out0,
    input  logic [7:0]        data_out1,
    input  logic [7:0]        data_out2,
    input  logic [7:0]        data_out3,
    input  logic              core_rd,
    output logic [31:0]       data_in,
    output logic              core_stall,
    output logic              err_flag,
    dmem_bus_bridge_if.master bus
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_stall;

    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [31:0]       r_data_in;
    logic              r_err_flag;

    logic              w_is_wr;
    logic              w_req;
    logic              w_be_ok;
    logic              w_legal;
    logic              w_accept;
    logic              w_misalign;
    logic              w_done_ok;
    logic              w_tmo_abort;

    // Request decode; a write always wins over a simultaneous load.
    assign w_is_wr    = |datamem_wr;
    assign w_req      = core_rd | w_is_wr;
    assign w_legal    = !w_is_wr || w_be_ok;
    assign w_accept   = (r_state == IDLE) && w_req && w_legal;
    assign w_misalign = (r_state == IDLE) && w_is_wr && !w_be_ok;
    assign w_done_ok  = (r_state == REQ) && bus.bus_ready;

    // Only naturally aligned byte, halfword and word enables are issued.
    always_comb begin
        w_be_ok = 1'b0;
        case (datamem_wr)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: w_be_ok = 1'b1;
            default:                   w_be_ok = 1'b0;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] r_tmo_cnt;
    logic [CNT_W-1:0] w_tmo_nxt;

    assign w_tmo_nxt   = r_tmo_cnt + 1'b1;
    // A ready in the limit cycle wins, so abort only when ready is absent.
    assign w_tmo_abort = (r_state == REQ) && !bus.bus_ready &&
                         (w_tmo_nxt >= CNT_W'(TIMEOUT_CYCLES));

    // Wait counter: cleared when a request enters REQ, counts unanswered REQ cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_tmo_cnt <= '0;
        else if (w_accept)
            r_tmo_cnt <= '0;
        else if ((r_state == REQ) && !bus.bus_ready)
            r_tmo_cnt <= w_tmo_nxt;
    end
`else
    assign w_tmo_abort = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next state and stall; DONE releases the core and ignores its stale request.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_stall     = 1'b1;
                    w_state_nxt = w_legal ? REQ : DONE;
                end
            end
            REQ: begin
                w_stall = 1'b1;
                if (bus.bus_ready || w_tmo_abort)
                    w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Stall is gated by reset so a core still presenting a request is released at once.
    assign core_stall = rstn & w_stall;

    // Request capture: bus fields are frozen from acceptance until the handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_be    <= 4'b0000;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_addr  <= data_addr & ~ADDR_W'(3);
            r_we    <= w_is_wr;
            r_be    <= w_is_wr ? datamem_wr : 4'b1111;
            r_wdata <= {data_out3, data_out2, data_out1, data_out0};
        end
    end

    // Read return and sticky error; writes never touch data_in.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data_in  <= '0;
            r_err_flag <= 1'b0;
        end else begin
            if (w_done_ok && !r_we)
                r_data_in <= bus.bus_err ? ERR_RDATA : bus.bus_rdata;
            else if (w_tmo_abort && !r_we)
                r_data_in <= ERR_RDATA;
            if (w_misalign || (w_done_ok && bus.bus_err) || w_tmo_abort)
                r_err_flag <= 1'b1;
        end
    end

    assign bus.bus_valid = (r_state == REQ);
    assign bus.bus_addr  = r_addr;
    assign bus.bus_we    = r_we;
    assign bus.bus_be    = r_be;
    assign bus.bus_wdata = r_wdata;
    assign data_in       = r_data_in;
    assign err_flag      = r_err_flag;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Testbench for dmem_bus_bridge: directed vector table, reset/timeout sequences,
// and randomized transactions checked against a transaction-level model.
module tb_dmem_bus_bridge;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] data_addr;
    logic [3:0]  datamem_wr;
    logic [7:0]  data_out0, data_out1, data_out2, data_out3;
    logic        core_rd;
    logic [31:0] data_in;
    logic        core_stall;
    logic        err_flag;

    dmem_bus_bridge_if #(.ADDR_W(32)) bus_if ();

    dmem_bus_bridge #(
        .ADDR_W(32), .TIMEOUT_CYCLES(TMO), .ERR_RDATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .rstn(rstn), .data_addr(data_addr), .datamem_wr(datamem_wr),
        .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2),
        .data_out3(data_out3), .core_rd(core_rd), .data_in(data_in),
        .core_stall(core_stall), .err_flag(err_flag), .bus(bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wr;
        logic        rd;
        logic [7:0]  d3, d2, d1, d0;
        int          waits;
        logic [31:0] rdata;
        logic        err;
        int          exp_issued;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        int          exp_stall;
        logic [31:0] exp_din;
        logic        exp_eflag;
    } txn_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: what the core should see after each completed access.
    logic [31:0] m_din;
    logic        m_eflag;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic txn_t mk(input logic [31:0] addr, input logic [3:0] wr, input logic rd,
                                input logic [31:0] wd, input int waits,
                                input logic [31:0] rdata, input logic err);
        txn_t t;
        t.addr = addr; t.wr = wr; t.rd = rd;
        t.d3 = wd[31:24]; t.d2 = wd[23:16]; t.d1 = wd[15:8]; t.d0 = wd[7:0];
        t.waits = waits; t.rdata = rdata; t.err = err;
        t.exp_issued = 0; t.exp_addr = 0; t.exp_we = 0; t.exp_be = 0;
        t.exp_wdata = 0; t.exp_stall = 0; t.exp_din = 0; t.exp_eflag = 0;
        return t;
    endfunction

    // Reference model: derive expected bus fields, stall length and core-visible
    // results from the access rules, then advance the model state.
    function automatic txn_t model(input txn_t t);
        txn_t r = t;
        bit is_wr  = (t.wr != 4'b0000);
        bit legal  = !is_wr || (t.wr inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                             4'b0011, 4'b1100, 4'b1111});
        bit tmo    = 1'b0;
`ifdef BUS_TIMEOUT_EN
        tmo = (t.waits >= TMO);
`endif
        r.exp_addr  = {t.addr[31:2], 2'b00};
        r.exp_we    = is_wr;
        r.exp_be    = is_wr ? t.wr : 4'b1111;
        r.exp_wdata = {t.d3, t.d2, t.d1, t.d0};
        if (!legal) begin
            r.exp_issued = 0;
            r.exp_stall  = 1;
            m_eflag      = 1'b1;
        end else begin
            r.exp_issued = 1;
            if (tmo) begin
                r.exp_stall = 1 + TMO;
                if (!is_wr) m_din = 32'hDEAD_BEEF;
                m_eflag = 1'b1;
            end else begin
                r.exp_stall = 2 + t.waits;
                if (!is_wr) m_din = t.err ? 32'hDEAD_BEEF : t.rdata;
                if (t.err) m_eflag = 1'b1;
            end
        end
        r.exp_din   = m_din;
        r.exp_eflag = m_eflag;
        return r;
    endfunction

    // Runs one access starting just after a rising edge with the DUT idle.
    // The slave answers after t.waits REQ cycles; outside REQ it drives noise
    // on ready/err that the bridge must ignore.
    task automatic run_txn(input string tag, input txn_t t);
        int  stall_cnt = 0;
        int  reqs      = 0;
        int  issued    = 0;
        bit  prev_v    = 1'b0;
        bit  done      = 1'b0;
        data_addr  = t.addr;
        datamem_wr = t.wr;
        core_rd    = t.rd;
        data_out3 = t.d3; data_out2 = t.d2; data_out1 = t.d1; data_out0 = t.d0;
        for (int c = 0; c < 64 && !done; c++) begin
            if (bus_if.bus_valid) begin
                reqs++;
                bus_if.bus_ready = (reqs > t.waits);
                bus_if.bus_rdata = bus_if.bus_ready ? t.rdata : $urandom;
                bus_if.bus_err   = bus_if.bus_ready ? t.err : 1'($urandom);
            end else begin
                bus_if.bus_ready = 1'($urandom);
                bus_if.bus_err   = 1'($urandom);
                bus_if.bus_rdata = $urandom;
            end
            @(negedge clk);
            if (core_stall) stall_cnt++;
            if (bus_if.bus_valid) begin
                if (!prev_v) issued++;
                chk({tag, ".addr"},  bus_if.bus_addr,  t.exp_addr);
                chk({tag, ".we"},    32'(bus_if.bus_we), 32'(t.exp_we));
                chk({tag, ".be"},    32'(bus_if.bus_be), 32'(t.exp_be));
                chk({tag, ".wdata"}, bus_if.bus_wdata, t.exp_wdata);
            end else if (stall_cnt > 0 && !core_stall) begin
                done = 1'b1;
                chk({tag, ".data_in"},  data_in, t.exp_din);
                chk({tag, ".err_flag"}, 32'(err_flag), 32'(t.exp_eflag));
            end
            prev_v = bus_if.bus_valid;
            @(posedge clk); #1;
        end
        bus_if.bus_ready = 1'b0;
        bus_if.bus_err   = 1'b0;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL %s.complete: access did not finish within 64 cycles", tag);
        end
        chk({tag, ".stall_cycles"}, 32'(stall_cnt), 32'(t.exp_stall));
        chk({tag, ".issued"},       32'(issued),    32'(t.exp_issued));
    endtask

    task automatic idle_core();
        data_addr = '0; datamem_wr = '0; core_rd = 1'b0;
        data_out0 = '0; data_out1 = '0; data_out2 = '0; data_out3 = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rstn = 1'b0;
        idle_core();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        m_din = '0; m_eflag = 1'b0;
    endtask

    txn_t vec[7];
    txn_t t;

    initial begin
        // Directed vectors with hand-derived expectations.
        vec[0] = mk(32'h0000_1006, 4'b0000, 1'b1, 32'h0,         0, 32'h1234_5678, 1'b0);
        vec[0].exp_issued = 1; vec[0].exp_addr = 32'h0000_1004; vec[0].exp_we = 0;
        vec[0].exp_be = 4'hF;  vec[0].exp_wdata = 32'h0; vec[0].exp_stall = 2;
        vec[0].exp_din = 32'h1234_5678; vec[0].exp_eflag = 0;
        vec[1] = mk(32'h0000_2000, 4'b1100, 1'b0, 32'hAABB_CCDD, 3, 32'h5555_5555, 1'b0);
        vec[1].exp_issued = 1; vec[1].exp_addr = 32'h0000_2000; vec[1].exp_we = 1;
        vec[1].exp_be = 4'hC;  vec[1].exp_wdata = 32'hAABB_CCDD; vec[1].exp_stall = 5;
        vec[1].exp_din = 32'h1234_5678; vec[1].exp_eflag = 0;
        vec[2] = mk(32'h0000_3003, 4'b0001, 1'b1, 32'h0000_005A, 1, 32'hFFFF_FFFF, 1'b0);
        vec[2].exp_issued = 1; vec[2].exp_addr = 32'h0000_3000; vec[2].exp_we = 1;
        vec[2].exp_be = 4'h1;  vec[2].exp_wdata = 32'h0000_005A; vec[2].exp_stall = 3;
        vec[2].exp_din = 32'h1234_5678; vec[2].exp_eflag = 0;
        vec[3] = mk(32'h0000_4008, 4'b0000, 1'b1, 32'h0,         0, 32'h1111_2222, 1'b1);
        vec[3].exp_issued = 1; vec[3].exp_addr = 32'h0000_4008; vec[3].exp_we = 0;
        vec[3].exp_be = 4'hF;  vec[3].exp_wdata = 32'h0; vec[3].exp_stall = 2;
        vec[3].exp_din = 32'hDEAD_BEEF; vec[3].exp_eflag = 1;
        vec[4] = mk(32'h0000_500C, 4'b1111, 1'b0, 32'h0102_0304, 2, 32'h0,         1'b0);
        vec[4].exp_issued = 1; vec[4].exp_addr = 32'h0000_500C; vec[4].exp_we = 1;
        vec[4].exp_be = 4'hF;  vec[4].exp_wdata = 32'h0102_0304; vec[4].exp_stall = 4;
        vec[4].exp_din = 32'hDEAD_BEEF; vec[4].exp_eflag = 1;
        vec[5] = mk(32'h0000_6000, 4'b0101, 1'b0, 32'h0102_0304, 0, 32'h0,         1'b0);
        vec[5].exp_issued = 0; vec[5].exp_stall = 1;
        vec[5].exp_din = 32'hDEAD_BEEF; vec[5].exp_eflag = 1;
        vec[6] = mk(32'h0000_7FFC, 4'b0000, 1'b1, 32'h0,         1, 32'hCAFE_F00D, 1'b0);
        vec[6].exp_issued = 1; vec[6].exp_addr = 32'h0000_7FFC; vec[6].exp_we = 0;
        vec[6].exp_be = 4'hF;  vec[6].exp_wdata = 32'h0; vec[6].exp_stall = 3;
        vec[6].exp_din = 32'hCAFE_F00D; vec[6].exp_eflag = 1;

        bus_if.bus_ready = 1'b0; bus_if.bus_err = 1'b0; bus_if.bus_rdata = '0;
        idle_core();
        rstn = 1'b0;
        #12;
        chk("rst.bus_valid", 32'(bus_if.bus_valid), 32'd0);
        chk("rst.core_stall", 32'(core_stall), 32'd0);
        chk("rst.bus_addr", bus_if.bus_addr, 32'd0);
        chk("rst.bus_we_be", {27'd0, bus_if.bus_we, bus_if.bus_be}, 32'd0);
        chk("rst.bus_wdata", bus_if.bus_wdata, 32'd0);
        chk("rst.data_in", data_in, 32'd0);
        chk("rst.err_flag", 32'(err_flag), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_txn($sformatf("vec%0d", i), vec[i]);

        // Reset while a read is waiting in REQ with the core still requesting.
        data_addr = 32'h0000_8000; core_rd = 1'b1; datamem_wr = 4'b0000;
        bus_if.bus_ready = 1'b0;
        for (int c = 0; c < 8 && !bus_if.bus_valid; c++) begin
            @(posedge clk); #1;
        end
        chk("midrst.valid_before", 32'(bus_if.bus_valid), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst.bus_valid", 32'(bus_if.bus_valid), 32'd0);
        chk("midrst.core_stall", 32'(core_stall), 32'd0);
        chk("midrst.err_flag", 32'(err_flag), 32'd0);
        chk("midrst.data_in", data_in, 32'd0);
        idle_core();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        m_din = '0; m_eflag = 1'b0;
        t = mk(32'h0000_8002, 4'b0000, 1'b1, 32'h0, 0, 32'h0BAD_F00D, 1'b0);
        run_txn("postrst", model(t));

        // Randomized accesses against the model.
        for (int i = 0; i < 40; i++) begin
            int   kind = $urandom_range(0, 3);
            logic [3:0] legal_be [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                         4'b0011, 4'b1100, 4'b1111};
            logic [3:0] bad_be   [8] = '{4'b0101, 4'b0110, 4'b0111, 4'b1001,
                                         4'b1010, 4'b1011, 4'b1101, 4'b1110};
            logic [3:0] wr;
            case (kind)
                0:       wr = 4'b0000;
                1:       wr = legal_be[$urandom_range(0, 6)];
                2:       wr = bad_be[$urandom_range(0, 7)];
                default: wr = legal_be[$urandom_range(0, 6)];
            endcase
            t = mk($urandom, wr, (kind == 0) || (kind == 3) || 1'($urandom),
                   $urandom, $urandom_range(0, 3), $urandom, ($urandom_range(0, 5) == 0));
            run_txn($sformatf("rnd%0d", i), model(t));
        end

`ifdef BUS_TIMEOUT_EN
        do_reset();
        t = mk(32'h0000_9000, 4'b0000, 1'b1, 32'h0, 1000, 32'h1357_9BDF, 1'b0);
        run_txn("timeout", model(t));
`else
        // No slave answer: the bridge must keep waiting.
        do_reset();
        data_addr = 32'h0000_9000; core_rd = 1'b1; datamem_wr = 4'b0000;
        bus_if.bus_ready = 1'b0;
        repeat (1000) @(posedge clk);
        @(negedge clk);
        chk("nowait.core_stall", 32'(core_stall), 32'd1);
        chk("nowait.bus_valid", 32'(bus_if.bus_valid), 32'd1);
        chk("nowait.err_flag", 32'(err_flag), 32'd0);
        do_reset();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_bus_bridge.md
Name: dmem_bus_bridge

Overview:
- Sits directly downstream of the riscv32b core's data port, between the LSU outputs and the SoC data bus.
- Turns the core's data request into a valid/ready bus transaction: address, byte-lane write enables, four write byte lanes, and a read strobe.
- Holds the core with a stall while a transaction is outstanding.
- Returns read data on the core's data_in.

Parameters:
- ADDR_W, 32, width of core and bus address.
- TIMEOUT_CYCLES, 255, bus wait limit in cycles. Used only with BUS_TIMEOUT_EN.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on a bus error or timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- data_addr  in  ADDR_W  core data address.
- datamem_wr  in  4  core byte write enables; bit n enables byte lane n.
- data_out0..data_out3  in  8 each  core write bytes, lane 0..3.
- core_rd  in  1  core load request (load-class Memtoreg).
- data_in  out  32  read data to the core.
- core_stall  out  1  core must hold its pipeline while high.
- bus_valid  out  1  transaction valid.
- bus_addr  out  ADDR_W  word-aligned address: {data_addr[ADDR_W-1:2], 2'b00}.
- bus_we  out  1  1 = write.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  {data_out3, data_out2, data_out1, data_out0}.
- bus_ready  in  1  slave accepts/completes the transaction this cycle.
- bus_rdata  in  32  slave read data, valid with bus_ready.
- bus_err  in  1  slave error, valid with bus_ready.
- err_flag  out  1  sticky error indicator.

Behaviour:
- Reset (asynchronous, immediate) sets: state=IDLE, bus_valid=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, data_in=0, err_flag=0, timeout counter=0.
- Reset mid-transaction drops bus_valid at once; the transaction is abandoned.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - A request is present when core_rd=1 or datamem_wr!=0.
  - On a request: core_stall=1 combinationally in the same cycle, and the request is latched into the bus_* registers.
  - Write: bus_we=1, bus_be=datamem_wr.
  - Read: bus_we=0, bus_be=4'b1111.
  - Next state REQ.
  - If a write and core_rd arrive together, the write wins and core_rd is ignored.
- REQ:
  - bus_valid=1; bus_addr, bus_we, bus_be and bus_wdata are held stable until the handshake.
  - core_stall=1.
  - On bus_ready=1: bus_valid drops on the next edge.
  - For a read, data_in captures bus_rdata, or ERR_RDATA if bus_err=1.
  - bus_err=1 on any transaction sets err_flag.
  - Next state DONE.
- DONE:
  - core_stall=0 so the core advances.
  - Core inputs are ignored this cycle, because they still carry the completed request.
  - Next state IDLE.
- data_in holds the last read result until the next read completes; writes do not change it.
- Latency: zero-wait slave gives request cycle, then REQ with ready, then DONE. Minimum 3 cycles per access, stall high for 2.
- Back-to-back requests: the next request is accepted in the IDLE cycle that follows DONE.
- bus_ready=1 outside REQ is ignored.
- err_flag is cleared only by reset.
- Misaligned enables (datamem_wr not one of 0001, 0010, 0100, 1000, 0011, 1100, 1111):
  - The transaction is not issued.
  - err_flag is set, and the FSM goes IDLE -> DONE directly (stall for 1 cycle).

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit-or-wider counter clears on entry to REQ and increments each REQ cycle without bus_ready.
  - When it reaches TIMEOUT_CYCLES, the transaction aborts: bus_valid drops, read data = ERR_RDATA, err_flag=1, next state DONE.
  - bus_ready arriving in the same cycle as the limit counts as a normal completion.
- Without the macro: no counter logic is present, and REQ waits indefinitely for bus_ready.

Test Plan:
- Read, zero-wait: core_rd=1, data_addr=0x0000_1006, bus_rdata=0x1234_5678 with bus_ready on the first REQ cycle -> bus_addr=0x0000_1004, bus_be=1111, stall high 2 cycles, data_in=0x1234_5678 in DONE.
- Write with 3 wait states: datamem_wr=1100, data_out3..0=AA,BB,CC,DD, ready after 3 cycles -> bus_wdata=0xAABBCCDD and bus_be=1100 stable throughout, bus_we=1, stall high 5 cycles, data_in unchanged.
- Bus error on read: bus_err=1 with bus_ready -> data_in=0xDEADBEEF, err_flag=1 and stays 1 until rstn=0.
- Simultaneous core_rd=1 and datamem_wr=0001 -> one write transaction only (bus_we=1, bus_be=0001).
- Reset mid-REQ: assert rstn=0 while bus_valid=1 -> bus_valid=0 and core_stall=0 immediately. After release, a new read completes normally.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, bus_ready held 0 -> abort after 4 REQ cycles, data_in=ERR_RDATA, err_flag=1. Without the macro, stall is still high after 1000 cycles.
